// File: rtl/hit_node_map.sv
// hit_node_map
// Hit-node-map store: an NROWS_HNM x NCOLS_HNM bitmap addressed by
// SSID = {row, col}. Serves single-bit SSID writes (OR-set), full-row
// writes, single-bit SSID reads and full-row reads, all in the same cycle
// if required. After reset the map clears itself one row per clock while
// busy is high; commands arriving during that sweep are dropped.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   write / SSID_write         set bit mem[row][col]
//   writeRow / rowWrite /
//   dataWrite                  overwrite one whole row
//   read / SSID_read           single-bit read request
//   readRow / rowRead          whole-row read request
//   writeReady, readReady      high while commands are accepted (IDLE)
//   SSID_passed, HNM_readOutput, HNM_readValid    single-bit read result
//   rowPassed, rowReadOutput, rowReadValid        row read result
//   busy                       clear sweep in progress
module hit_node_map #(
  parameter int ROWINDEXBITS_HNM = 4,
  parameter int COLINDEXBITS_HNM = 4,
  parameter int NROWS_HNM        = 16,
  parameter int NCOLS_HNM        = 16,
  parameter int SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write,
  input  logic [SSIDBITS-1:0]         SSID_write,
  input  logic                        writeRow,
  input  logic [ROWINDEXBITS_HNM-1:0] rowWrite,
  input  logic [NCOLS_HNM-1:0]        dataWrite,
  input  logic                        read,
  input  logic [SSIDBITS-1:0]         SSID_read,
  input  logic                        readRow,
  input  logic [ROWINDEXBITS_HNM-1:0] rowRead,
  output logic                        writeReady,
  output logic                        readReady,
  output logic [SSIDBITS-1:0]         SSID_passed,
  output logic                        HNM_readOutput,
  output logic                        HNM_readValid,
  output logic [ROWINDEXBITS_HNM-1:0] rowPassed,
  output logic [NCOLS_HNM-1:0]        rowReadOutput,
  output logic                        rowReadValid,
  output logic                        busy
);

  localparam int RB = ROWINDEXBITS_HNM;
  localparam int CB = COLINDEXBITS_HNM;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t         state;
  logic [RB-1:0]  clearPtr;

  logic [NCOLS_HNM-1:0] mem     [NROWS_HNM];
  logic [NCOLS_HNM-1:0] rowNext [NROWS_HNM];

  // SSID fields
  logic [RB-1:0] ssidWRow, ssidRRow;
  logic [CB-1:0] ssidWCol, ssidRCol;

  assign ssidWRow = SSID_write[SSIDBITS-1 -: RB];
  assign ssidWCol = SSID_write[CB-1:0];
  assign ssidRRow = SSID_read[SSIDBITS-1 -: RB];
  assign ssidRCol = SSID_read[CB-1:0];

  // Index range checks; the extra bit keeps NROWS/NCOLS = 2^bits representable.
  function automatic logic rowOk(input logic [RB-1:0] r);
    return {1'b0, r} < (RB+1)'(NROWS_HNM);
  endfunction

  function automatic logic colOk(input logic [CB-1:0] c);
    return {1'b0, c} < (CB+1)'(NCOLS_HNM);
  endfunction

  logic                 bitWriteOk, rowWriteOk, bitReadOk, rowReadOk;
  logic [NCOLS_HNM-1:0] colMask;

  assign bitWriteOk = write && rowOk(ssidWRow) && colOk(ssidWCol);
  assign rowWriteOk = writeRow && rowOk(rowWrite);
  assign bitReadOk  = rowOk(ssidRRow) && colOk(ssidRCol);
  assign rowReadOk  = rowOk(rowRead);
  assign colMask    = NCOLS_HNM'(1) << ssidWCol;

  // Next value of every row in IDLE. The row write is applied first and
  // the SSID bit is OR-ed on top, so a same-cycle row write and bit write
  // to one row combine to dataWrite | (1 << col).
  genvar gi;
  generate
    for (gi = 0; gi < NROWS_HNM; gi++) begin : g_rowNext
      assign rowNext[gi] =
        ((rowWriteOk && rowWrite == RB'(gi)) ? dataWrite : mem[gi]) |
        ((bitWriteOk && ssidWRow == RB'(gi)) ? colMask : '0);
    end
  endgenerate

  // Storage has no reset of its own; the sweep clears it row by row.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      if (rowOk(clearPtr)) begin
        mem[clearPtr] <= '0;
      end
    end else begin
      for (int r = 0; r < NROWS_HNM; r++) begin
        mem[r] <= rowNext[r];
      end
    end
  end

  // Control FSM with registered outputs. Reads sample mem before the
  // same-edge update above, giving read-before-write behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= CLEAR;
      clearPtr       <= '0;
      busy           <= 1'b1;
      writeReady     <= 1'b0;
      readReady      <= 1'b0;
      SSID_passed    <= '0;
      HNM_readOutput <= 1'b0;
      HNM_readValid  <= 1'b0;
      rowPassed      <= '0;
      rowReadOutput  <= '0;
      rowReadValid   <= 1'b0;
    end else begin
      HNM_readValid <= 1'b0;
      rowReadValid  <= 1'b0;
      case (state)
        CLEAR: begin
          clearPtr <= clearPtr + 1'b1;
          if (clearPtr == RB'(NROWS_HNM - 1)) begin
            state      <= IDLE;
            clearPtr   <= '0;
            busy       <= 1'b0;
            writeReady <= 1'b1;
            readReady  <= 1'b1;
          end
        end
        IDLE: begin
          if (read) begin
            HNM_readValid  <= 1'b1;
            SSID_passed    <= SSID_read;
            HNM_readOutput <= bitReadOk ? mem[ssidRRow][ssidRCol] : 1'b0;
          end
          if (readRow) begin
            rowReadValid  <= 1'b1;
            rowPassed     <= rowRead;
            rowReadOutput <= rowReadOk ? mem[rowRead] : '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_node_map.sv
// Testbench for hit_node_map: reset sweep timing, a table of directed
// command vectors with hand-computed results, and sequences for the
// mid-sweep reset, dropped commands and asynchronous output clearing.
module tb_hit_node_map;

  logic        clk;
  logic        reset;
  logic        write;
  logic [7:0]  SSID_write;
  logic        writeRow;
  logic [3:0]  rowWrite;
  logic [15:0] dataWrite;
  logic        read;
  logic [7:0]  SSID_read;
  logic        readRow;
  logic [3:0]  rowRead;
  logic        writeReady;
  logic        readReady;
  logic [7:0]  SSID_passed;
  logic        HNM_readOutput;
  logic        HNM_readValid;
  logic [3:0]  rowPassed;
  logic [15:0] rowReadOutput;
  logic        rowReadValid;
  logic        busy;

  hit_node_map dut (
    .clk(clk), .reset(reset),
    .write(write), .SSID_write(SSID_write),
    .writeRow(writeRow), .rowWrite(rowWrite), .dataWrite(dataWrite),
    .read(read), .SSID_read(SSID_read),
    .readRow(readRow), .rowRead(rowRead),
    .writeReady(writeReady), .readReady(readReady),
    .SSID_passed(SSID_passed), .HNM_readOutput(HNM_readOutput),
    .HNM_readValid(HNM_readValid),
    .rowPassed(rowPassed), .rowReadOutput(rowReadOutput),
    .rowReadValid(rowReadValid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nRun  = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCmds();
    write = 0; SSID_write = 0; writeRow = 0; rowWrite = 0; dataWrite = 0;
    read = 0; SSID_read = 0; readRow = 0; rowRead = 0;
  endtask

  // Counts edges until busy drops. With dropCmds set, every command is
  // driven throughout; none may produce a valid pulse or touch memory.
  task automatic waitSweep(input string name, input bit dropCmds);
    int n = 0;
    if (dropCmds) begin
      write = 1; SSID_write = 8'h01;
      writeRow = 1; rowWrite = 4'd1; dataWrite = 16'hFFFF;
      read = 1; SSID_read = 8'h01;
      readRow = 1; rowRead = 4'd1;
    end
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (dropCmds) begin
        chk($sformatf("%s.rowValid@%0d", name, n), rowReadValid, 0);
        chk($sformatf("%s.bitValid@%0d", name, n), HNM_readValid, 0);
      end
    end
    idleCmds();
    chk({name, ".busyCycles"}, n, 16);
    chk({name, ".writeReady"}, writeReady, 1);
    chk({name, ".readReady"}, readReady, 1);
  endtask

  task automatic readAllZero(input string name);
    for (int r = 0; r < 16; r++) begin
      readRow = 1; rowRead = 4'(r);
      tick();
      chk($sformatf("%s.valid%0d", name, r), rowReadValid, 1);
      chk($sformatf("%s.row%0d", name, r), rowReadOutput, 0);
      chk($sformatf("%s.passed%0d", name, r), rowPassed, r);
    end
    readRow = 0;
    tick();
    chk({name, ".validDrop"}, rowReadValid, 0);
  endtask

  typedef struct {
    logic        wr;   logic [7:0]  sw;
    logic        wrow; logic [3:0]  rw;  logic [15:0] dw;
    logic        rd;   logic [7:0]  sr;
    logic        rrow; logic [3:0]  rr;
    logic        eBv;  logic        eBit; logic [7:0] eSp;
    logic        eRv;  logic [15:0] eRow; logic [3:0] eRp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // wr sw  wrow rw dw | rd sr | rrow rr | eBv eBit eSp | eRv eRow eRp
    vecs[0]  = '{1, 8'h80, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[1]  = '{1, 8'h83, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[2]  = '{1, 8'h87, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[3]  = '{1, 8'h88, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[4]  = '{1, 8'h46, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[5]  = '{1, 8'h4C, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[6]  = '{1, 8'h18, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[7]  = '{1, 8'h83, 0, 0, 0,        0, 0,     0, 0,  0, 0, 8'h00, 0, 16'h0000, 15};
    vecs[8]  = '{0, 0,     0, 0, 0,        0, 0,     1, 8,  0, 0, 8'h00, 1, 16'h0189, 8};
    vecs[9]  = '{0, 0,     0, 0, 0,        0, 0,     1, 4,  0, 0, 8'h00, 1, 16'h1040, 4};
    vecs[10] = '{0, 0,     0, 0, 0,        0, 0,     1, 1,  0, 0, 8'h00, 1, 16'h0100, 1};
    vecs[11] = '{0, 0,     0, 0, 0,        1, 8'h4C, 1, 15, 1, 1, 8'h4C, 1, 16'h0000, 15};
    vecs[12] = '{0, 0,     0, 0, 0,        1, 8'h4D, 0, 0,  1, 0, 8'h4D, 0, 16'h0000, 15};
    vecs[13] = '{1, 8'h31, 1, 3, 16'h5555, 0, 0,     1, 3,  0, 0, 8'h4D, 1, 16'h0000, 3};
    vecs[14] = '{0, 0,     0, 0, 0,        1, 8'h31, 1, 3,  1, 1, 8'h31, 1, 16'h5557, 3};
    vecs[15] = '{0, 0,     0, 0, 0,        0, 0,     0, 0,  0, 1, 8'h31, 0, 16'h5557, 3};
    vecs[16] = '{0, 0,     1, 8, 16'h0000, 0, 0,     1, 8,  0, 1, 8'h31, 1, 16'h0189, 8};
    vecs[17] = '{0, 0,     0, 0, 0,        1, 8'h80, 1, 8,  1, 0, 8'h80, 1, 16'h0000, 8};
    vecs[18] = '{1, 8'h22, 0, 0, 0,        1, 8'h22, 0, 0,  1, 0, 8'h22, 0, 16'h0000, 8};
    vecs[19] = '{0, 0,     0, 0, 0,        1, 8'h22, 0, 0,  1, 1, 8'h22, 0, 16'h0000, 8};

    // Reset state
    idleCmds();
    reset = 1;
    tick();
    tick();
    chk("rst.busy", busy, 1);
    chk("rst.writeReady", writeReady, 0);
    chk("rst.readReady", readReady, 0);
    chk("rst.rowValid", rowReadValid, 0);
    chk("rst.bitValid", HNM_readValid, 0);
    chk("rst.rowOut", rowReadOutput, 0);
    chk("rst.ssidPassed", SSID_passed, 0);
    reset = 0;
    waitSweep("sweep1", 0);
    readAllZero("clear1");

    // Directed command table, one cycle per vector
    for (int i = 0; i < 20; i++) begin
      write = vecs[i].wr; SSID_write = vecs[i].sw;
      writeRow = vecs[i].wrow; rowWrite = vecs[i].rw; dataWrite = vecs[i].dw;
      read = vecs[i].rd; SSID_read = vecs[i].sr;
      readRow = vecs[i].rrow; rowRead = vecs[i].rr;
      tick();
      chk($sformatf("v%0d.bitValid", i), HNM_readValid, vecs[i].eBv);
      chk($sformatf("v%0d.bitOut", i), HNM_readOutput, vecs[i].eBit);
      chk($sformatf("v%0d.ssidPassed", i), SSID_passed, vecs[i].eSp);
      chk($sformatf("v%0d.rowValid", i), rowReadValid, vecs[i].eRv);
      chk($sformatf("v%0d.rowOut", i), rowReadOutput, vecs[i].eRow);
      chk($sformatf("v%0d.rowPassed", i), rowPassed, vecs[i].eRp);
    end
    idleCmds();

    // Asynchronous clearing of outputs on reset assertion
    readRow = 1; rowRead = 4'd3;
    tick();
    readRow = 0;
    chk("pre.rowOut", rowReadOutput, 16'h5557);
    #2 reset = 1;
    #1;
    chk("async.rowOut", rowReadOutput, 0);
    chk("async.rowValid", rowReadValid, 0);
    chk("async.ssidPassed", SSID_passed, 0);
    chk("async.busy", busy, 1);
    chk("async.readReady", readReady, 0);
    tick();
    reset = 0;

    // Restart the sweep at cycle 7; commands meanwhile must be dropped
    write = 1; SSID_write = 8'h01; writeRow = 1; rowWrite = 4'd0; dataWrite = 16'hFFFF;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk($sformatf("mid.busy%0d", c), busy, 1);
    end
    idleCmds();
    reset = 1;
    tick();
    reset = 0;
    waitSweep("sweep2", 1);
    readAllZero("clear2");

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/hit_node_map.md
# hit_node_map

Synthesizable hit-node-map (HNM) store: the responder side of the HNM command interface that pattern-matching front ends and benches drive. Holds an NROWS_HNM × NCOLS_HNM bitmap addressed by SSID = {row, col}. Accepts single-bit SSID writes, full-row writes, single-bit SSID reads and full-row reads. Clears itself by sequential sweep after reset, signalling `busy` for the duration.

## Interface
- ROWINDEXBITS_HNM, 4, row index width
- COLINDEXBITS_HNM, 4, column index width
- NROWS_HNM, 16, number of rows (≤ 2^ROWINDEXBITS_HNM)
- NCOLS_HNM, 16, bits per row (≤ 2^COLINDEXBITS_HNM)
- SSIDBITS, ROWINDEXBITS_HNM+COLINDEXBITS_HNM, SSID width; SSID = {row, col}

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- write  in  1  SSID write strobe (set one bit)
- SSID_write  in  SSIDBITS  SSID to set
- writeRow  in  1  row write strobe
- rowWrite  in  ROWINDEXBITS_HNM  row to overwrite
- dataWrite  in  NCOLS_HNM  row data
- read  in  1  SSID read strobe
- SSID_read  in  SSIDBITS  SSID to read
- readRow  in  1  row read strobe
- rowRead  in  ROWINDEXBITS_HNM  row to read
- writeReady  out  1  write commands accepted this cycle
- readReady  out  1  read commands accepted this cycle
- SSID_passed  out  SSIDBITS  SSID of returned bit
- HNM_readOutput  out  1  returned bit
- HNM_readValid  out  1  SSID_passed/HNM_readOutput valid
- rowPassed  out  ROWINDEXBITS_HNM  row of returned data
- rowReadOutput  out  NCOLS_HNM  returned row
- rowReadValid  out  1  rowPassed/rowReadOutput valid
- busy  out  1  clear sweep in progress

## Operation
- Storage: register array mem[NROWS_HNM][NCOLS_HNM].
- States: CLEAR, IDLE. reset asserted → state CLEAR, clear pointer 0, all outputs 0 except busy=1.
- CLEAR: each clock after reset deasserts, mem[ptr] ← 0, ptr+1; after row NROWS_HNM-1 cleared → IDLE. busy=1, writeReady=readReady=0 throughout. Reset reasserted mid-sweep restarts at ptr 0.
- IDLE: busy=0, writeReady=readReady=1. All four commands independent, may be asserted in the same cycle.
- Commands arriving in CLEAR are dropped: no memory change, no valid pulse.
- SSID write: mem[row][col] ← 1 (OR; never clears a bit).
- Row write: mem[rowWrite] ← dataWrite.
- writeRow and write on same row, same cycle: final row = dataWrite | (1<<col).
- Row index ≥ NROWS_HNM or col ≥ NCOLS_HNM: write ignored. A read still returns a valid pulse with data 0.
- SSID read: HNM_readOutput ← mem[row][col], SSID_passed ← SSID_read, HNM_readValid ← 1.
- Row read: rowReadOutput ← mem[rowRead], rowPassed ← rowRead, rowReadValid ← 1.
- Reads sample memory before same-cycle writes (read-before-write).
- Data outputs hold their last value when the valid signal is 0.

## Timing
- Reset sweep: busy high from reset assertion through exactly NROWS_HNM rising edges after deassertion. busy low on the edge after the last row is cleared.
- Read latency 1 cycle: strobe sampled at edge N → outputs/valid at edge N; visible in cycle N+1. Valid pulses are one cycle per strobe.
- Throughput 1 read of each kind and 1 write of each kind per cycle, back-to-back.
- Write visible to a read issued the next cycle or later.
- Reset values: all data outputs 0, valids 0, ready 0, busy 1.

## Test plan
- Reset 1 cycle, then release: busy high exactly 16 cycles, then ready=1. Row reads of 0..15 → all rowReadOutput=0, rowReadValid one cycle after each strobe.
- Write SSIDs {8,0},{8,3},{8,7},{8,8},{4,6},{4,12},{1,8} back-to-back, then read rows 8, 4 and 1 → 0x0189, 0x1040, 0x0100. Duplicate writes are harmless.
- Same cycle: writeRow row 3 = 0x5555 and write SSID {3,1} → row 3 reads 0x5557. A row read of row 3 issued in that same cycle returns the old value 0.
- SSID read of {4,12} → HNM_readOutput=1, SSID_passed=0x4C. SSID read of {4,13} → 0. Row read of row 15 without prior writes → 0.
- Assert reset mid-sweep (cycle 7) → ptr restarts; busy stays high 16 cycles after the second release. Writes issued while busy=1 are absent on later readback.
- Reset after data is stored → all rows read 0 after the sweep; outputs go to 0 asynchronously on assertion.
